// File: rtl/beam_scaler_pkg.sv
// Shared types, default widths and the saturating increment used by the
// beam trigger scaler.
package beam_scaler_pkg;

  typedef enum logic {IDLE, RUN} scaler_state_e;

  localparam int unsigned DEF_CNT_BITS    = 16;
  localparam int unsigned DEF_PERIOD_BITS = 24;

  // Adds one when inc is set, sticking at max_val.
  function automatic logic [31:0] sat_inc(input logic [31:0] val,
                                          input logic        inc,
                                          input logic [31:0] max_val);
    return (inc && (val < max_val)) ? val + 32'd1 : val;
  endfunction

endpackage

// File: rtl/beam_trig_counter.sv
// One scaler channel: rising-edge detect, saturating live counter and
// live saturation flag.
module beam_trig_counter
  import beam_scaler_pkg::*;
#(
  parameter int unsigned CNT_BITS = DEF_CNT_BITS
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                trig_i,
  input  logic                count_en_i,
  input  logic                clear_i,
  input  logic                capture_i,
  output logic [CNT_BITS-1:0] cap_cnt_o,
  output logic                cap_sat_o
);

  localparam logic [31:0] CNT_MAX = 32'((64'd1 << CNT_BITS) - 64'd1);

  logic                prev_q;
  logic [CNT_BITS-1:0] cnt_q;
  logic                sat_q;
  logic                rise_w;

  assign rise_w = trig_i & ~prev_q;

  // Capture outputs include the current cycle's edge so the last gate cycle counts.
  assign cap_cnt_o = CNT_BITS'(sat_inc(32'(cnt_q), rise_w, CNT_MAX));
  assign cap_sat_o = sat_q | (rise_w & (&cnt_q));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      prev_q <= 1'b0;
      cnt_q  <= '0;
      sat_q  <= 1'b0;
    end else begin
      prev_q <= trig_i;
      if (clear_i || capture_i) begin
        cnt_q <= '0;
        sat_q <= 1'b0;
      end else if (count_en_i) begin
        cnt_q <= cap_cnt_o;
        sat_q <= cap_sat_o;
      end
    end
  end

endmodule

// File: rtl/beam_trigger_scaler.sv
// Gated rising-edge scaler for the beamformer trigger bits, with a shadow
// bank latched at each gate end and a registered read port.
module beam_trigger_scaler
  import beam_scaler_pkg::*;
#(
  parameter int unsigned NBEAMS      = 2,
  parameter int unsigned CNT_BITS    = DEF_CNT_BITS,
  parameter int unsigned PERIOD_BITS = DEF_PERIOD_BITS
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [2*NBEAMS-1:0]           trigger_i,
  input  logic                          enable_i,
  input  logic [PERIOD_BITS-1:0]        period_i,
  input  logic                          rd_en_i,
  input  logic [$clog2(2*NBEAMS)-1:0]   rd_addr_i,
  output logic [CNT_BITS-1:0]           rd_data_o,
  output logic                          rd_valid_o,
  output logic [2*NBEAMS-1:0]           sat_o,
  output logic                          period_done_o
);

  localparam int unsigned NCH = 2 * NBEAMS;

  scaler_state_e          state_q, state_d;
  logic [PERIOD_BITS-1:0] gcnt_q;
  logic                   clear, capture, count_en, load, done_d;
  logic                   start_ok;

  logic [CNT_BITS-1:0]    cap_cnt  [NCH];
  logic [NCH-1:0]         cap_sat;
  logic [CNT_BITS-1:0]    shadow_q [NCH];
  logic [NCH-1:0]         sat_q;

  assign start_ok = enable_i && (|period_i);

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    beam_trig_counter #(.CNT_BITS(CNT_BITS)) u_cnt (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .trig_i     (trigger_i[k]),
      .count_en_i (count_en),
      .clear_i    (clear),
      .capture_i  (capture),
      .cap_cnt_o  (cap_cnt[k]),
      .cap_sat_o  (cap_sat[k])
    );
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    clear    = 1'b0;
    capture  = 1'b0;
    count_en = 1'b0;
    load     = 1'b0;
    done_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        clear = 1'b1;
        if (start_ok) begin
          state_d = RUN;
          load    = 1'b1;
        end
      end
      RUN: begin
        // Gate completion takes priority over an abort on the last cycle.
        if (gcnt_q == '0) begin
          capture = 1'b1;
          done_d  = 1'b1;
          if (start_ok) load    = 1'b1;
          else          state_d = IDLE;
        end else if (!enable_i) begin
          clear   = 1'b1;
          state_d = IDLE;
        end else begin
          count_en = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                 gcnt_q <= '0;
    else if (load)             gcnt_q <= period_i - PERIOD_BITS'(1);
    else if (state_d == IDLE)  gcnt_q <= '0;
    else                       gcnt_q <= gcnt_q - PERIOD_BITS'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned k = 0; k < NCH; k++) shadow_q[k] <= '0;
      sat_q         <= '0;
      period_done_o <= 1'b0;
    end else begin
      period_done_o <= done_d;
      if (capture) begin
        for (int unsigned k = 0; k < NCH; k++) shadow_q[k] <= cap_cnt[k];
        sat_q <= cap_sat;
      end
    end
  end

  assign sat_o = sat_q;

  // Reads sample the bank before any same-cycle capture lands.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_data_o  <= '0;
      rd_valid_o <= 1'b0;
    end else begin
      rd_valid_o <= rd_en_i;
      if (rd_en_i)
        rd_data_o <= (32'(rd_addr_i) < NCH) ? shadow_q[rd_addr_i] : '0;
    end
  end

endmodule
